// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI frame decoder driving register bursts; SPI_CMD_TIMEOUT_EN adds a stall timeout
module spi_cmd_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 7,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RD_REQ = 3'd3;
  localparam logic [2:0] S_RD_LAT = 3'd4;
  localparam logic [2:0] S_RD_TX  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // The command word must exactly hold the R/W bit, address and length fields.
  generate
    if (DATA_W != 1 + ADDR_W + LEN_W || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
      $error("spi_cmd_ctrl: inconsistent parameters");
    end
  endgenerate

  logic [2:0]        state;
  logic              cs_s1, cs_s2, cs_d;
  logic              rx_q, tx_q;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic              cs_fall, cs_hi, tmo;

  assign cs_fall = cs_d & ~cs_s2;
  assign cs_hi   = cs_s2;
  assign busy    = (state != S_IDLE);

  // CS synchroniser; flops clear to 0 so a CS held low through reset never looks like a new falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1 <= 1'b0;
      cs_s2 <= 1'b0;
      cs_d  <= 1'b0;
    end else begin
      cs_s1 <= spi_cs;
      cs_s2 <= cs_s1;
      cs_d  <= cs_s2;
    end
  end

  // Delay the done pulses one cycle so rx_data is sampled when the slave says it is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= 1'b0;
      tx_q <= 1'b0;
    end else begin
      rx_q <= rx_done;
      tx_q <= tx_done;
    end
  end

`ifdef SPI_CMD_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] idle_cnt;
  logic        idle_run;

  assign idle_run = ((state == S_CMD) || (state == S_WR) || (state == S_RD_TX)) && !cs_hi;
  assign tmo      = idle_run && (idle_cnt == TIMEOUT_LIM) && !rx_done && !tx_done;

  // Idle counter: restarts on any SPI word activity, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= 16'd0;
    else if (!idle_run || rx_done || tx_done)
      idle_cnt <= 16'd0;
    else if (idle_cnt != TIMEOUT_LIM)
      idle_cnt <= idle_cnt + 16'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  // Frame state machine; strobes are single-cycle and default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      cnt        <= '0;
      tx_data    <= '0;
      tx_en      <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      tx_en      <= 1'b0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cs_fall) state <= S_CMD;
        end
        S_CMD: begin
          if (rx_q) begin
            addr <= rx_data[DATA_W-2 -: ADDR_W];
            cnt  <= rx_data[LEN_W-1:0];
            if (rx_data[DATA_W-1]) begin
              reg_rd   <= 1'b1;
              reg_addr <= rx_data[DATA_W-2 -: ADDR_W];
              state    <= S_RD_REQ;
            end else begin
              state <= S_WR;
            end
          end else if (cs_hi && !rx_done) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (tmo) begin
            frame_err <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_WR: begin
          // A received word is committed before any abort is considered.
          if (rx_q) begin
            reg_wr    <= 1'b1;
            reg_addr  <= addr;
            reg_wdata <= rx_data;
            addr      <= addr + 1'b1;
            if (cnt == '0) begin
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else if (cs_hi && !rx_done) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (tmo) begin
            frame_err <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_RD_REQ: begin
          if (cs_hi) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            state <= S_RD_LAT;
          end
        end
        S_RD_LAT: begin
          if (cs_hi) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tx_data <= reg_rdata;
            tx_en   <= 1'b1;
            state   <= S_RD_TX;
          end
        end
        S_RD_TX: begin
          if (tx_q) begin
            addr <= addr + 1'b1;
            if (cnt == '0) begin
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              cnt      <= cnt - 1'b1;
              reg_rd   <= 1'b1;
              reg_addr <= addr + 1'b1;
              state    <= S_RD_REQ;
            end
          end else if (cs_hi && !tx_done) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (tmo) begin
            frame_err <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (cs_hi) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - directed self-checking bench for spi_cmd_ctrl
module tb_spi_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs = 1'b1;
  logic [15:0] rx_data = '0;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic [15:0] reg_rdata = '0;
  logic [15:0] tx_data;
  logic        tx_en;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr, reg_rd, busy, frame_done, frame_err;

  spi_cmd_ctrl #(.DATA_W(16), .ADDR_W(7), .LEN_W(8), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .rx_data(rx_data), .rx_done(rx_done),
    .tx_done(tx_done), .tx_data(tx_data), .tx_en(tx_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register file model: read data {addr,addr}, valid one cycle after reg_rd.
  always @(posedge clk) if (reg_rd) reg_rdata <= {1'b0, reg_addr, 1'b0, reg_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_n = 0, rd_n = 0, txen_n = 0, fd_n = 0, fe_n = 0, both_n = 0, last_rx = 0;
  logic [6:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          wr_lat_q[$];
  int          txen_lat_q[$];

  // Monitor on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rx_done || tx_done) last_rx = cyc;
    if (reg_wr) begin
      wr_n++;
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
      wr_lat_q.push_back(cyc - last_rx);
    end
    if (reg_rd) rd_n++;
    if (tx_en) begin
      txen_n++;
      txen_lat_q.push_back(cyc - last_rx);
    end
    if (frame_done) fd_n++;
    if (frame_err) fe_n++;
    if (reg_wr && reg_rd) both_n++;
  end

  int checks = 0, errors = 0;
  int gap = 20;
  int tx_used = 0;
  logic [15:0] miso_q[$];
  int w0, r0, t0, m0, fd0, fe0;
  logic [6:0] wrap_a[3] = '{7'h7F, 7'h00, 7'h01};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SPI word: gap cycles, then rx_done (and tx_done if a TX word was armed).
  task automatic word(input logic [15:0] d);
    repeat (gap) tick();
    rx_data = d;
    rx_done = 1'b1;
    if (txen_n > tx_used) begin
      tx_done = 1'b1;
      miso_q.push_back(tx_data);
      tx_used = txen_n;
    end
    tick();
    rx_done = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    repeat (6) tick();
  endtask

  task automatic snap();
    w0 = wr_n; r0 = rd_n; t0 = txen_n; m0 = miso_q.size(); fd0 = fd_n; fe0 = fe_n;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {reg_wr, reg_rd, tx_en, frame_done, frame_err}, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_txdata", tx_data, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single write
    snap();
    cs_low(); word(16'h0500); word(16'hA5A5); repeat (4) tick();
    chk("sw_count", wr_n - w0, 1);
    chk("sw_addr", wr_addr_q[w0], 7'h05);
    chk("sw_data", wr_data_q[w0], 16'hA5A5);
    chk("sw_lat", wr_lat_q[w0], 2);
    chk("sw_done", fd_n - fd0, 1);
    chk("sw_busy_done", busy, 1);
    cs_high();
    chk("sw_err", fe_n - fe0, 0);
    chk("sw_idle", busy, 0);

    // burst write wrapping the address
    snap();
    cs_low(); word(16'h7F02); word(16'd1); word(16'd2); word(16'd3); repeat (4) tick();
    chk("wrap_count", wr_n - w0, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_addr%0d", i), wr_addr_q[w0+i], wrap_a[i]);
      chk($sformatf("wrap_data%0d", i), wr_data_q[w0+i], i + 1);
    end
    chk("wrap_done", fd_n - fd0, 1);
    cs_high();
    chk("wrap_err", fe_n - fe0, 0);

    // burst read of two words
    snap();
    cs_low(); word(16'h8A01); word(16'h0000); word(16'h0000); repeat (4) tick();
    chk("rd_miso0", miso_q[m0], 16'h0A0A);
    chk("rd_miso1", miso_q[m0+1], 16'h0B0B);
    chk("rd_txen_n", txen_n - t0, 2);
    chk("rd_txen_lat0", txen_lat_q[t0], 4);
    chk("rd_txen_lat1", txen_lat_q[t0+1], 4);
    chk("rd_rd_n", rd_n - r0, 2);
    chk("rd_no_wr", wr_n - w0, 0);
    chk("rd_done", fd_n - fd0, 1);
    cs_high();
    chk("rd_err", fe_n - fe0, 0);

    // abort after two of four words, then a normal frame
    snap();
    cs_low(); word(16'h1003); word(16'hAAAA); word(16'hBBBB); cs_high();
    chk("ab_count", wr_n - w0, 2);
    chk("ab_addr0", wr_addr_q[w0], 7'h10);
    chk("ab_addr1", wr_addr_q[w0+1], 7'h11);
    chk("ab_err", fe_n - fe0, 1);
    chk("ab_nodone", fd_n - fd0, 0);
    chk("ab_busy", busy, 0);
    snap();
    cs_low(); word(16'h2000); word(16'h1234); repeat (4) tick(); cs_high();
    chk("ab2_count", wr_n - w0, 1);
    chk("ab2_addr", wr_addr_q[w0], 7'h20);
    chk("ab2_data", wr_data_q[w0], 16'h1234);
    chk("ab2_done", fd_n - fd0, 1);
    chk("ab2_err", fe_n - fe0, 0);

    // overrun: extra words after a one-word write are ignored
    snap();
    cs_low(); word(16'h0300); word(16'h1111); word(16'h2222); word(16'h3333); word(16'h4444);
    repeat (4) tick();
    chk("ov_count", wr_n - w0, 1);
    chk("ov_data", wr_data_q[w0], 16'h1111);
    chk("ov_txen", txen_n - t0, 0);
    chk("ov_done", fd_n - fd0, 1);
    cs_high();
    chk("ov_err", fe_n - fe0, 0);

    // maximum length burst: LEN field 0xFF is 256 words
    snap();
    gap = 10;
    cs_low(); word(16'h40FF);
    for (int i = 0; i < 255; i++) word(16'(i));
    repeat (4) tick();
    chk("max_not_done", fd_n - fd0, 0);
    chk("max_busy", busy, 1);
    word(16'h00FF); repeat (4) tick();
    chk("max_count", wr_n - w0, 256);
    chk("max_first_addr", wr_addr_q[w0], 7'h40);
    chk("max_last_addr", wr_addr_q[w0+255], 7'h3F);
    chk("max_last_data", wr_data_q[w0+255], 16'h00FF);
    chk("max_done", fd_n - fd0, 1);
    cs_high();
    chk("max_err", fe_n - fe0, 0);
    gap = 20;

    // stalled frame: SCK stops with CS low
    snap();
    cs_low(); word(16'h0501); word(16'h5555); repeat (300) tick();
`ifdef SPI_CMD_TIMEOUT_EN
    chk("to_err", fe_n - fe0, 1);
    chk("to_busy", busy, 1);
    cs_high();
    chk("to_err_total", fe_n - fe0, 1);
`else
    chk("stall_err", fe_n - fe0, 0);
    chk("stall_busy", busy, 1);
    cs_high();
    chk("stall_err_cs", fe_n - fe0, 1);
`endif
    chk("stall_nodone", fd_n - fd0, 0);
    chk("stall_idle", busy, 0);

    // reset mid-frame; CS stays low so no new frame may start
    snap();
    cs_low(); word(16'h0700);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    word(16'h1234); repeat (4) tick();
    chk("mrst_no_wr", wr_n - w0, 0);
    chk("mrst_idle", busy, 0);
    cs_high();
    chk("mrst_err", fe_n - fe0, 0);

    chk("excl_wr_rd", both_n, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
